// File: rtl/nn_layer_seq.sv
// nn_layer_seq: sequencer for one fully-connected layer instance.
// Clears the layer, streams NUM_INPUTS activations from the input buffer
// (address-aligned with the per-neuron weight memories), waits for every
// neuron to report valid, then captures the output vector.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; result/result_valid/timeout_err hold
// CLEAR  | one-cycle layer_clr to the neurons
// STREAM | issue buffer reads at cnt while in_avail is high
// DRAIN  | final read's data/valid reaches the layer
// WAIT   | wait for all neuron valids, bounded by TIMEOUT cycles
// DONE   | one-cycle done pulse; result captured
// ERR    | sticky timeout_err raised; no done pulse
module nn_layer_seq #(
  parameter int NUM_INPUTS    = 784,
  parameter int NUM_NEURONS   = 128,
  parameter int DATA_WIDTH    = 16,
  parameter int IN_ADDR_WIDTH = 10,
  parameter int TIMEOUT       = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              timeout_err,
  input  logic                              in_avail,
  output logic                              in_rd_en,
  output logic [IN_ADDR_WIDTH-1:0]          in_rd_addr,
  input  logic [DATA_WIDTH-1:0]             in_rd_data,
  output logic                              layer_clr,
  output logic [DATA_WIDTH-1:0]             layer_data_in,
  output logic                              layer_input_valid,
  output logic [31:0]                       layer_local_addr,
  input  logic [NUM_NEURONS-1:0]            layer_out_valids,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] layer_out,
  output logic [NUM_NEURONS*DATA_WIDTH-1:0] result,
  output logic                              result_valid
);

  // The WAIT budget is a down-counter loaded with TIMEOUT-1 on DRAIN;
  // reaching zero while still waiting is the terminal count.
  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0]         TMR_LOAD  = TMR_W'(TIMEOUT - 1);
  localparam logic [IN_ADDR_WIDTH-1:0] LAST_ADDR = IN_ADDR_WIDTH'(NUM_INPUTS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_WAIT   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [IN_ADDR_WIDTH-1:0] cnt;
  logic [IN_ADDR_WIDTH-1:0] last_addr;
  logic [TMR_W-1:0]         tmr;
  logic                     all_valid;
  logic                     tmr_tc;
  logic                     accept;

  assign all_valid = &layer_out_valids;
  assign tmr_tc    = (tmr == '0);
  assign accept    = (state == S_IDLE) && start;

  // State register; reset aborts any pass in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; all-valid takes priority over the timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_CLEAR;
      S_CLEAR:  state_nxt = S_STREAM;
      S_STREAM: if (in_avail && (cnt == LAST_ADDR)) state_nxt = S_DRAIN;
      S_DRAIN:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (all_valid)   state_nxt = S_DONE;
        else if (tmr_tc) state_nxt = S_ERR;
      end
      S_DONE:   state_nxt = S_IDLE;
      S_ERR:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Moore/Mealy outputs decoded from the current state.
  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    layer_clr = (state == S_CLEAR);
    in_rd_en  = (state == S_STREAM) && in_avail;
  end

  assign in_rd_addr    = cnt;
  assign layer_data_in = in_rd_data;
  // Shows the address being issued this cycle, otherwise the last one issued.
  assign layer_local_addr = in_rd_en ? 32'(cnt) : 32'(last_addr);

  // Read address counter and last-issued address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      last_addr <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (in_rd_en) begin
      cnt       <= cnt + 1'b1;
      last_addr <= cnt;
    end
  end

  // Input-valid delayed one stage to line up with the 1-cycle read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) layer_input_valid <= 1'b0;
    else      layer_input_valid <= in_rd_en;
  end

  // WAIT budget timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          tmr <= '0;
    else if (state == S_DRAIN)         tmr <= TMR_LOAD;
    else if (state == S_WAIT && !tmr_tc) tmr <= tmr - 1'b1;
  end

  // Result capture and status flags; both cleared by an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result       <= '0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
    end else if (accept) begin
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
    end else if (state == S_WAIT) begin
      if (all_valid) begin
        result       <= layer_out;
        result_valid <= 1'b1;
      end else if (tmr_tc) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nn_layer_seq.sv
// Bench for nn_layer_seq: input-buffer and layer models, a per-cycle
// scoreboard on the stream, and per-pass cycle masks against literal values.
module tb_nn_layer_seq;
  localparam int NI = 4;
  localparam int NN = 2;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int TO = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             busy, done, timeout_err;
  logic             in_avail;
  logic             in_rd_en;
  logic [AW-1:0]    in_rd_addr;
  logic [DW-1:0]    in_rd_data;
  logic             layer_clr;
  logic [DW-1:0]    layer_data_in;
  logic             layer_input_valid;
  logic [31:0]      layer_local_addr;
  logic [NN-1:0]    layer_out_valids;
  logic [NN*DW-1:0] layer_out;
  logic [NN*DW-1:0] result;
  logic             result_valid;

  always #5 clk = ~clk;

  nn_layer_seq #(
    .NUM_INPUTS(NI), .NUM_NEURONS(NN), .DATA_WIDTH(DW),
    .IN_ADDR_WIDTH(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .timeout_err(timeout_err), .in_avail(in_avail), .in_rd_en(in_rd_en),
    .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data), .layer_clr(layer_clr),
    .layer_data_in(layer_data_in), .layer_input_valid(layer_input_valid),
    .layer_local_addr(layer_local_addr), .layer_out_valids(layer_out_valids),
    .layer_out(layer_out), .result(result), .result_valid(result_valid)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- models ----------------
  logic [DW-1:0] mem [NI];
  bit            stuck = 0;
  int            cyc = 0;
  bit            s_rd_en, s_clr, s_valid;
  logic [AW-1:0] s_rd_addr;
  int            s_cyc;
  int            lv_count = 0;
  int            lv_last  = 0;
  int            exp_iss  = 0;
  int            exp_val  = 0;

  // Input buffer answers one cycle after a strobe; the layer raises its
  // valids three cycles after the last activation (or sticks at 2'b01).
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (!rst) begin
      in_rd_data       = '0;
      layer_out_valids = '0;
      lv_count         = 0;
    end else begin
      if (s_rd_en) in_rd_data = (int'(s_rd_addr) < NI) ? mem[s_rd_addr] : 16'hBAD0;
      else         in_rd_data = 16'hDEAD;
      if (s_clr) lv_count = 0;
      else if (s_valid) begin
        lv_count++;
        if (lv_count == NI) lv_last = s_cyc;
      end
      if (lv_count >= NI && cyc >= lv_last + 3)
        layer_out_valids = stuck ? 2'b01 : 2'b11;
      else
        layer_out_valids = 2'b00;
    end
  end

  // Compare process: addresses in order, data matches address, done carries result.
  always @(negedge clk) begin
    s_rd_en = in_rd_en; s_rd_addr = in_rd_addr; s_clr = layer_clr;
    s_valid = layer_input_valid; s_cyc = cyc;
    if (!rst) begin
      exp_iss = 0; exp_val = 0;
    end else begin
      if (layer_clr) begin exp_iss = 0; exp_val = 0; end
      if (in_rd_en) begin
        check("issue_when_avail", in_avail, 1);
        check("rd_addr_order", in_rd_addr, exp_iss);
        check("local_addr_order", layer_local_addr, exp_iss);
        exp_iss++;
      end
      if (layer_input_valid) begin
        check("act_data", layer_data_in, (exp_val < NI) ? mem[exp_val] : 16'hBAD1);
        exp_val++;
      end
      if (done) begin
        check("done_valid_count", exp_val, NI);
        check("done_result", result, layer_out);
        check("done_result_valid", result_valid, 1);
      end
    end
  end

  // ---------------- directed passes ----------------
  logic [31:0] en_m, val_m, clr_m, done_m, busy_m, rv_m, terr_m;
  int          addr_a [32];
  int          laddr_a [32];

  task automatic run_pass(input int ncyc, input int st_lo, input int st_hi, input int hold);
    en_m = 0; val_m = 0; clr_m = 0; done_m = 0; busy_m = 0; rv_m = 0; terr_m = 0;
    @(posedge clk); #1;
    start = 1'b1; in_avail = 1'b1;
    for (int c = 0; c <= ncyc; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        start    = (c <= hold);
        in_avail = !(c >= st_lo && c <= st_hi);
      end
      @(negedge clk);
      en_m[c] = in_rd_en; val_m[c] = layer_input_valid; clr_m[c] = layer_clr;
      done_m[c] = done; busy_m[c] = busy; rv_m[c] = result_valid;
      terr_m[c] = timeout_err;
      addr_a[c] = int'(in_rd_addr); laddr_a[c] = int'(layer_local_addr);
    end
    start = 1'b0; in_avail = 1'b1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_terr"}, timeout_err, 0);
    check({tag, "_rd_en"}, in_rd_en, 0);
    check({tag, "_rd_addr"}, in_rd_addr, 0);
    check({tag, "_clr"}, layer_clr, 0);
    check({tag, "_ivalid"}, layer_input_valid, 0);
    check({tag, "_laddr"}, layer_local_addr, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_rvalid"}, result_valid, 0);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) mem[i] = DW'(16'h1111 * (i + 1));
    rst = 1'b0; start = 1'b0; in_avail = 1'b1; layer_out = 32'h0003_0005;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b1;

    // 1: no stalls
    run_pass(12, 99, 99, 0);
    check("p1_en", en_m, 32'h0000_003C);
    check("p1_valid", val_m, 32'h0000_0078);
    check("p1_clr", clr_m, 32'h0000_0002);
    check("p1_done", done_m, 32'h0000_0400);
    check("p1_busy", busy_m, 32'h0000_07FE);
    check("p1_rv", rv_m, 32'h0000_1C00);
    check("p1_terr", terr_m, 32'h0);
    check("p1_addr2", addr_a[2], 0);
    check("p1_addr5", addr_a[5], 3);
    check("p1_laddr5", laddr_a[5], 3);
    check("p1_laddr_idle", laddr_a[11], 3);
    check("p1_result", result, 32'h0003_0005);

    // 2: in_avail low in cycles 3-4
    run_pass(14, 3, 4, 0);
    check("p2_en", en_m, 32'h0000_00E4);
    check("p2_valid", val_m, 32'h0000_01C8);
    check("p2_done", done_m, 32'h0000_1000);
    check("p2_busy", busy_m, 32'h0000_1FFE);
    check("p2_rv", rv_m, 32'h0000_7001);
    check("p2_addr3", addr_a[3], 1);
    check("p2_addr4", addr_a[4], 1);
    check("p2_addr7", addr_a[7], 3);
    check("p2_laddr_carry", laddr_a[1], 3);
    check("p2_laddr_stall", laddr_a[4], 0);

    // 3: valids stuck at 2'b01 -> timeout
    stuck = 1;
    run_pass(20, 99, 99, 0);
    check("p3_en", en_m, 32'h0000_003C);
    check("p3_done", done_m, 32'h0);
    check("p3_terr", terr_m, 32'h001F_8000);
    check("p3_busy", busy_m, 32'h0000_FFFE);
    check("p3_rv", rv_m, 32'h0000_0001);

    // 4: next start clears the sticky error
    stuck = 0;
    run_pass(12, 99, 99, 0);
    check("p4_terr", terr_m, 32'h0000_0001);
    check("p4_done", done_m, 32'h0000_0400);
    check("p4_rv", rv_m, 32'h0000_1C00);

    // 5: start held high through the first pass
    layer_out = 32'hBEEF_1234;
    run_pass(24, 99, 99, 11);
    check("p5_clr", clr_m, 32'h0000_1002);
    check("p5_done", done_m, 32'h0020_0400);
    check("p5_rv", rv_m, 32'h01E0_0C01);
    check("p5_result", result, 32'hBEEF_1234);

    // 6: reset in STREAM at cnt=2
    @(posedge clk); #1;
    start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("p6_pre_rd_en", in_rd_en, 1);
    check("p6_pre_addr", in_rd_addr, 2);
    rst = 1'b0;
    #1;
    check_zero_outputs("p6_async");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("p6_no_done", done, 0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    run_pass(12, 99, 99, 0);
    check("p6_en", en_m, 32'h0000_003C);
    check("p6_addr2", addr_a[2], 0);
    check("p6_done", done_m, 32'h0000_0400);
    check("p6_rv", rv_m, 32'h0000_1C00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
